// File: rtl/kbd_text_ctrl_pkg.sv
// Shared scancode constants, FSM/cursor encodings and the shift-case helper
// for the keyboard-to-text-buffer sequencer.
package kbd_text_ctrl_pkg;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] SC_BKSP     = 8'h66;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CUR_NONE    = 2'd0,
        CUR_ADVANCE = 2'd1,
        CUR_RETREAT = 2'd2,
        CUR_NEWLINE = 2'd3
    } cur_op_t;

    // Shift only upper-cases lowercase letters; digits and punctuation pass through.
    function automatic logic [7:0] apply_shift(input logic [7:0] ch, input logic shift);
        if (shift && (ch >= 8'h61) && (ch <= 8'h7A))
            return ch - 8'h20;
        return ch;
    endfunction

endpackage

// File: rtl/kbd_text_ctrl_cursor.sv
// Combinational cursor arithmetic: advance, retreat and newline with
// column/row wrap; retreat from (0,0) is reported as not valid.
module kbd_text_ctrl_cursor
    import kbd_text_ctrl_pkg::*;
#(
    parameter int COL_W = 5,
    parameter int ROW_W = 7
) (
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    input  cur_op_t          op,
    output logic [COL_W-1:0] next_col,
    output logic [ROW_W-1:0] next_row,
    output logic             valid
);

    localparam logic [COL_W-1:0] COL_MAX = '1;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        next_col = col;
        next_row = row;
        valid    = 1'b1;
        unique case (op)
            CUR_ADVANCE: begin
                if (col == COL_MAX) begin
                    next_col = '0;
                    next_row = row + ROW_W'(1);
                end else begin
                    next_col = col + COL_W'(1);
                end
            end
            CUR_RETREAT: begin
                if ((col == '0) && (row == '0)) begin
                    valid = 1'b0;
                end else if (col == '0) begin
                    next_col = COL_MAX;
                    next_row = row - ROW_W'(1);
                end else begin
                    next_col = col - COL_W'(1);
                end
            end
            CUR_NEWLINE: begin
                next_col = '0;
                next_row = row + ROW_W'(1);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/kbd_text_ctrl.sv
// Turns PS/2 scancode bytes into text RAM writes: tracks break/extended/shift
// prefixes, looks each byte up in the sync ASCII ROM and owns the text cursor.
module kbd_text_ctrl
    import kbd_text_ctrl_pkg::*;
#(
    parameter int COL_W  = 5,
    parameter int ROW_W  = 7,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sc_valid,
    input  logic [7:0]        sc_data,
    output logic              sc_ready,
    output logic [7:0]        lut_addr,
    input  logic [7:0]        lut_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [COL_W-1:0]  cur_col,
    output logic [ROW_W-1:0]  cur_row,
    output logic              shift_o,
    output logic [7:0]        char_cnt
);

    state_t           state, next_state;
    logic [7:0]       code_q;
    logic             brk, ext;
    logic             is_shift_code;
    logic             lookup_to_write;
    cur_op_t          cur_op;
    logic [COL_W-1:0] nxt_col;
    logic [ROW_W-1:0] nxt_row;
    logic             nxt_valid;

    assign is_shift_code   = (code_q == SC_LSHIFT) || (code_q == SC_RSHIFT);
    // Prefixes, any pending break/extended byte and shift makes end in LOOKUP.
    assign lookup_to_write = !((code_q == SC_BREAK) || (code_q == SC_EXT) ||
                               brk || ext || is_shift_code);

    always_comb begin
        cur_op = CUR_ADVANCE;
        if (code_q == SC_ENTER)
            cur_op = CUR_NEWLINE;
        else if (code_q == SC_BKSP)
            cur_op = CUR_RETREAT;
    end

    kbd_text_ctrl_cursor #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_cursor (
        .col      (cur_col),
        .row      (cur_row),
        .op       (cur_op),
        .next_col (nxt_col),
        .next_row (nxt_row),
        .valid    (nxt_valid)
    );

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (sc_valid) next_state = ST_LOOKUP;
            ST_LOOKUP: next_state = lookup_to_write ? ST_WRITE : ST_IDLE;
            ST_WRITE:  next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // sc_ready is held low while reset is asserted so every output reads 0 then.
    always_comb begin
        sc_ready = (state == ST_IDLE) && !rst;
        lut_addr = code_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q   <= '0;
            brk      <= 1'b0;
            ext      <= 1'b0;
            shift_o  <= 1'b0;
            cur_col  <= '0;
            cur_row  <= '0;
            char_cnt <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (sc_valid)
                        code_q <= sc_data;
                end
                ST_LOOKUP: begin
                    if (code_q == SC_BREAK) begin
                        brk <= 1'b1;
                    end else if (code_q == SC_EXT) begin
                        ext <= 1'b1;
                    end else if (brk) begin
                        brk <= 1'b0;
                        ext <= 1'b0;
                        if (is_shift_code)
                            shift_o <= 1'b0;
                    end else if (ext) begin
                        ext <= 1'b0;
                    end else if (is_shift_code) begin
                        shift_o <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (code_q == SC_ENTER) begin
                        cur_col <= nxt_col;
                        cur_row <= nxt_row;
                    end else if (code_q == SC_BKSP) begin
                        if (nxt_valid) begin
                            cur_col <= nxt_col;
                            cur_row <= nxt_row;
                            wr_en   <= 1'b1;
                            wr_addr <= {nxt_col, nxt_row};
                            wr_data <= ASCII_SPACE;
                        end
                    end else if (lut_data != 8'h00) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= {cur_col, cur_row};
                        wr_data  <= apply_shift(lut_data, shift_o);
                        cur_col  <= nxt_col;
                        cur_row  <= nxt_row;
                        char_cnt <= char_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
